decode_stage: RTL and testbench

Instruction-decode stage of the 5-stage scalar/vector pipelined CPU. Splits the 30-bit instruction into fields and holds the 8-entry scalar and 8-entry vector register files, with combinational reads and write-back from WB. Also holds the lane mask register, which is loaded by vector compares in Execute and passed down the pipe. Sits between the Fetch/Decode and Decode/Execute pipeline registers.

---
 rtl/decode_stage.sv | 166 ++++++++++++++++
 tb/tb_decode_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction-decode stage of the scalar/vector pipelined CPU.
// Splits the instruction word into its fields, holds the scalar and vector
// register files (asynchronous reads with write-through bypass from WB) and
// the lane mask register that Execute loads with vector compare results.
module decode_stage #(
  parameter int DATA_WIDTH        = 19,
  parameter int VECTOR_SIZE       = 6,
  parameter int SCALAR_REGNUM     = 8,
  parameter int VECTOR_REGNUM     = 8,
  parameter int ADDRESS_WIDTH     = 3,
  parameter int OPCODE_WIDTH      = 5,
  parameter int INSTRUCTION_WIDTH = 30
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [INSTRUCTION_WIDTH-1:0]      instruction,
  input  logic                              writeEnableScalar,
  input  logic                              writeEnableVector,
  input  logic [ADDRESS_WIDTH-1:0]          writeAddress,
  input  logic [DATA_WIDTH-1:0]             writeScalarData,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] writeVectorData,
  input  logic                              weMaskVector,
  input  logic                              resetMaskVector,
  input  logic [VECTOR_SIZE-1:0]            maskVectorIn,
  output logic [OPCODE_WIDTH-1:0]           opcode,
  output logic [ADDRESS_WIDTH-1:0]          regDestinationAddress,
  output logic [ADDRESS_WIDTH-1:0]          reg1Address,
  output logic [ADDRESS_WIDTH-1:0]          reg2Address,
  output logic [DATA_WIDTH-1:0]             inmediate,
  output logic [DATA_WIDTH-1:0]             reg1ScalarContent,
  output logic [DATA_WIDTH-1:0]             reg2ScalarContent,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] reg1VectorContent,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] reg2VectorContent,
  output logic [VECTOR_SIZE-1:0]            maskVectorOut
);

  localparam int VEC_W  = VECTOR_SIZE * DATA_WIDTH;
  // Field layout, MSB first: opcode | rd | rs1 | rs2/immediate.
  localparam int RD_MSB = INSTRUCTION_WIDTH - OPCODE_WIDTH - 1;
  localparam int R1_MSB = RD_MSB - ADDRESS_WIDTH;
  localparam int R2_MSB = R1_MSB - ADDRESS_WIDTH;
  localparam int IMM_W  = R2_MSB + 1;

  logic [DATA_WIDTH-1:0] scalar_rf_q [SCALAR_REGNUM];
  logic [DATA_WIDTH-1:0] scalar_rf_d [SCALAR_REGNUM];
  logic [VEC_W-1:0]      vector_rf_q [VECTOR_REGNUM];
  logic [VEC_W-1:0]      vector_rf_d [VECTOR_REGNUM];
  logic [VECTOR_SIZE-1:0] mask_q;
  logic [VECTOR_SIZE-1:0] mask_d;

  logic [ADDRESS_WIDTH-1:0] rs1_addr;
  logic [ADDRESS_WIDTH-1:0] rs2_addr;

  // Field decode: pure wiring, zero latency, unaffected by reset.
  assign opcode                = instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign regDestinationAddress = instruction[RD_MSB -: ADDRESS_WIDTH];
  assign rs1_addr              = instruction[R1_MSB -: ADDRESS_WIDTH];
  assign rs2_addr              = instruction[R2_MSB -: ADDRESS_WIDTH];
  assign reg1Address           = rs1_addr;
  assign reg2Address           = rs2_addr;

  // The immediate overlaps rs2; the consumer picks whichever it needs.
  generate
    if (DATA_WIDTH > IMM_W) begin : g_imm_zext
      assign inmediate = {{(DATA_WIDTH-IMM_W){1'b0}}, instruction[IMM_W-1:0]};
    end else begin : g_imm_trunc
      assign inmediate = instruction[DATA_WIDTH-1:0];
    end
  endgenerate

  // Next state of the scalar register file: one write port from WB.
  always_comb begin
    scalar_rf_d = scalar_rf_q;
    if (writeEnableScalar) begin
      scalar_rf_d[writeAddress] = writeScalarData;
    end
  end

  // Next state of the vector register file, independent of the scalar file.
  always_comb begin
    vector_rf_d = vector_rf_q;
    if (writeEnableVector) begin
      vector_rf_d[writeAddress] = writeVectorData;
    end
  end

  // Mask next state: clearing to all ones wins over a load from Execute.
  always_comb begin
    mask_d = mask_q;
    if (resetMaskVector) begin
      mask_d = '1;
    end else if (weMaskVector) begin
      mask_d = maskVectorIn;
    end
  end

  // Scalar register file storage; reset clears every entry at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SCALAR_REGNUM; i++) begin
        scalar_rf_q[i] <= '0;
      end
    end else begin
      scalar_rf_q <= scalar_rf_d;
    end
  end

  // Vector register file storage; reset clears every entry at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VECTOR_REGNUM; i++) begin
        vector_rf_q[i] <= '0;
      end
    end else begin
      vector_rf_q <= vector_rf_d;
    end
  end

  // Lane mask register; all lanes enabled out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  // Scalar reads with write-through bypass so Decode sees the value in WB.
  // The bypass is suppressed in reset because the write itself is blocked.
  always_comb begin
    reg1ScalarContent = scalar_rf_q[rs1_addr];
    reg2ScalarContent = scalar_rf_q[rs2_addr];
    if (reset) begin
      reg1ScalarContent = '0;
      reg2ScalarContent = '0;
    end else begin
      if (writeEnableScalar && (writeAddress == rs1_addr)) begin
        reg1ScalarContent = writeScalarData;
      end
      if (writeEnableScalar && (writeAddress == rs2_addr)) begin
        reg2ScalarContent = writeScalarData;
      end
    end
  end

  // Vector reads, bypassed the same way as the scalar ports.
  always_comb begin
    reg1VectorContent = vector_rf_q[rs1_addr];
    reg2VectorContent = vector_rf_q[rs2_addr];
    if (reset) begin
      reg1VectorContent = '0;
      reg2VectorContent = '0;
    end else begin
      if (writeEnableVector && (writeAddress == rs1_addr)) begin
        reg1VectorContent = writeVectorData;
      end
      if (writeEnableVector && (writeAddress == rs2_addr)) begin
        reg2VectorContent = writeVectorData;
      end
    end
  end

  // The mask is only ever seen as registered; Execute does the lane gating.
  assign maskVectorOut = mask_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: field decode, register file writes,
// write-through bypass, mask register priority and asynchronous reset.
module tb_decode_stage;

  localparam int DW = 19;
  localparam int VS = 6;
  localparam int AW = 3;
  localparam int VW = VS * DW;

  logic          clock;
  logic          reset;
  logic [29:0]   instruction;
  logic          writeEnableScalar;
  logic          writeEnableVector;
  logic [AW-1:0] writeAddress;
  logic [DW-1:0] writeScalarData;
  logic [VW-1:0] writeVectorData;
  logic          weMaskVector;
  logic          resetMaskVector;
  logic [VS-1:0] maskVectorIn;
  logic [4:0]    opcode;
  logic [AW-1:0] regDestinationAddress;
  logic [AW-1:0] reg1Address;
  logic [AW-1:0] reg2Address;
  logic [DW-1:0] inmediate;
  logic [DW-1:0] reg1ScalarContent;
  logic [DW-1:0] reg2ScalarContent;
  logic [VW-1:0] reg1VectorContent;
  logic [VW-1:0] reg2VectorContent;
  logic [VS-1:0] maskVectorOut;

  int tests;
  int fails;

  decode_stage dut (
    .clock                 (clock),
    .reset                 (reset),
    .instruction           (instruction),
    .writeEnableScalar     (writeEnableScalar),
    .writeEnableVector     (writeEnableVector),
    .writeAddress          (writeAddress),
    .writeScalarData       (writeScalarData),
    .writeVectorData       (writeVectorData),
    .weMaskVector          (weMaskVector),
    .resetMaskVector       (resetMaskVector),
    .maskVectorIn          (maskVectorIn),
    .opcode                (opcode),
    .regDestinationAddress (regDestinationAddress),
    .reg1Address           (reg1Address),
    .reg2Address           (reg2Address),
    .inmediate             (inmediate),
    .reg1ScalarContent     (reg1ScalarContent),
    .reg2ScalarContent     (reg2ScalarContent),
    .reg1VectorContent     (reg1VectorContent),
    .reg2VectorContent     (reg2VectorContent),
    .maskVectorOut         (maskVectorOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [29:0] mk_instr(input logic [4:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs1, input logic [2:0] rs2,
                                           input logic [15:0] lo);
    return {op, rd, rs1, rs2, lo};
  endfunction

  // Vector whose lane i holds base+i.
  function automatic logic [VW-1:0] mk_vec(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < VS; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    writeEnableScalar = 1'b0;
    writeEnableVector = 1'b0;
    weMaskVector      = 1'b0;
    resetMaskVector   = 1'b0;
  endtask

  task automatic test_reset();
    instruction = mk_instr(5'd0, 3'd0, 3'd1, 3'd2, 16'd0);
    #2;
    tests++; if (reg1ScalarContent !== '0) begin fails++; $display("FAIL rst_r1s got=%h exp=0", reg1ScalarContent); end
    tests++; if (reg2ScalarContent !== '0) begin fails++; $display("FAIL rst_r2s got=%h exp=0", reg2ScalarContent); end
    tests++; if (reg1VectorContent !== '0) begin fails++; $display("FAIL rst_r1v got=%h exp=0", reg1VectorContent); end
    tests++; if (reg2VectorContent !== '0) begin fails++; $display("FAIL rst_r2v got=%h exp=0", reg2VectorContent); end
    tests++; if (maskVectorOut !== 6'b111111) begin fails++; $display("FAIL rst_mask got=%b exp=111111", maskVectorOut); end
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_decode();
    instruction = 30'b00011_101_010_011_0000000000000101;
    #1;
    tests++; if (opcode !== 5'd3) begin fails++; $display("FAIL dec_op got=%0d exp=3", opcode); end
    tests++; if (regDestinationAddress !== 3'd5) begin fails++; $display("FAIL dec_rd got=%0d exp=5", regDestinationAddress); end
    tests++; if (reg1Address !== 3'd2) begin fails++; $display("FAIL dec_rs1 got=%0d exp=2", reg1Address); end
    tests++; if (reg2Address !== 3'd3) begin fails++; $display("FAIL dec_rs2 got=%0d exp=3", reg2Address); end
    // instruction[18:0] = 011 followed by 16'h0005.
    tests++; if (inmediate !== 19'h30005) begin fails++; $display("FAIL dec_imm got=%h exp=30005", inmediate); end
    instruction = 30'h3FFF_FFFF;
    #1;
    tests++; if (inmediate !== 19'h7FFFF) begin fails++; $display("FAIL dec_imm_ones got=%h exp=7ffff", inmediate); end
    tests++; if (opcode !== 5'd31) begin fails++; $display("FAIL dec_op_ones got=%0d exp=31", opcode); end
  endtask

  task automatic test_scalar_write();
    idle_inputs();
    writeEnableScalar = 1'b1;
    writeAddress      = 3'd2;
    writeScalarData   = 19'd1234;
    instruction       = mk_instr(5'd1, 3'd0, 3'd0, 3'd1, 16'd0);
    tick();
    writeEnableScalar = 1'b0;
    writeScalarData   = 19'd999;
    instruction       = mk_instr(5'd1, 3'd0, 3'd2, 3'd0, 16'd0);
    #1;
    tests++; if (reg1ScalarContent !== 19'd1234) begin fails++; $display("FAIL sw_r1s got=%0d exp=1234", reg1ScalarContent); end
    tests++; if (reg1VectorContent !== '0) begin fails++; $display("FAIL sw_vec_clean got=%h exp=0", reg1VectorContent); end
    tests++; if (reg2ScalarContent !== '0) begin fails++; $display("FAIL sw_r2s_r0 got=%0d exp=0", reg2ScalarContent); end
    // Scalar bypass on port 2 only.
    writeEnableScalar = 1'b1;
    writeAddress      = 3'd0;
    writeScalarData   = 19'd77;
    #1;
    tests++; if (reg2ScalarContent !== 19'd77) begin fails++; $display("FAIL sbyp_r2s got=%0d exp=77", reg2ScalarContent); end
    tests++; if (reg1ScalarContent !== 19'd1234) begin fails++; $display("FAIL sbyp_r1s got=%0d exp=1234", reg1ScalarContent); end
    tick();
    idle_inputs();
    #1;
    tests++; if (reg2ScalarContent !== 19'd77) begin fails++; $display("FAIL sbyp_store got=%0d exp=77", reg2ScalarContent); end
  endtask

  task automatic test_vector_bypass();
    logic [VW-1:0] lanes;
    lanes = mk_vec(1);
    idle_inputs();
    instruction       = mk_instr(5'd2, 3'd0, 3'd4, 3'd4, 16'd0);
    #1;
    tests++; if (reg1VectorContent !== '0) begin fails++; $display("FAIL vbyp_pre got=%h exp=0", reg1VectorContent); end
    writeEnableVector = 1'b1;
    writeAddress      = 3'd4;
    writeVectorData   = lanes;
    #1;
    tests++; if (reg1VectorContent !== lanes) begin fails++; $display("FAIL vbyp_r1v got=%h exp=%h", reg1VectorContent, lanes); end
    tests++; if (reg2VectorContent !== lanes) begin fails++; $display("FAIL vbyp_r2v got=%h exp=%h", reg2VectorContent, lanes); end
    tests++; if (reg1ScalarContent !== '0) begin fails++; $display("FAIL vbyp_scalar got=%h exp=0", reg1ScalarContent); end
    tick();
    writeEnableVector = 1'b0;
    writeVectorData   = '0;
    #1;
    tests++; if (reg1VectorContent !== lanes) begin fails++; $display("FAIL vbyp_store1 got=%h exp=%h", reg1VectorContent, lanes); end
    tests++; if (reg2VectorContent !== lanes) begin fails++; $display("FAIL vbyp_store2 got=%h exp=%h", reg2VectorContent, lanes); end
  endtask

  task automatic test_mask();
    idle_inputs();
    weMaskVector = 1'b1;
    maskVectorIn = 6'b010110;
    #1;
    tests++; if (maskVectorOut !== 6'b111111) begin fails++; $display("FAIL mask_nobyp got=%b exp=111111", maskVectorOut); end
    tick();
    weMaskVector = 1'b0;
    maskVectorIn = 6'b000001;
    #1;
    tests++; if (maskVectorOut !== 6'b010110) begin fails++; $display("FAIL mask_load got=%b exp=010110", maskVectorOut); end
    tick();
    tests++; if (maskVectorOut !== 6'b010110) begin fails++; $display("FAIL mask_hold got=%b exp=010110", maskVectorOut); end
    weMaskVector    = 1'b1;
    resetMaskVector = 1'b1;
    tick();
    tests++; if (maskVectorOut !== 6'b111111) begin fails++; $display("FAIL mask_prio got=%b exp=111111", maskVectorOut); end
    resetMaskVector = 1'b0;
    maskVectorIn    = 6'b100001;
    tick();
    tests++; if (maskVectorOut !== 6'b100001) begin fails++; $display("FAIL mask_reload got=%b exp=100001", maskVectorOut); end
    idle_inputs();
  endtask

  task automatic test_dual_write();
    logic [VW-1:0] vv;
    vv = mk_vec(100);
    idle_inputs();
    instruction       = mk_instr(5'd3, 3'd0, 3'd7, 3'd6, 16'd0);
    writeEnableScalar = 1'b1;
    writeEnableVector = 1'b1;
    writeAddress      = 3'd7;
    writeScalarData   = 19'h5A5A5;
    writeVectorData   = vv;
    tick();
    idle_inputs();
    writeScalarData = '0;
    writeVectorData = '0;
    #1;
    tests++; if (reg1ScalarContent !== 19'h5A5A5) begin fails++; $display("FAIL dual_s7 got=%h exp=5a5a5", reg1ScalarContent); end
    tests++; if (reg1VectorContent !== vv) begin fails++; $display("FAIL dual_v7 got=%h exp=%h", reg1VectorContent, vv); end
    tests++; if (reg2ScalarContent !== '0) begin fails++; $display("FAIL dual_s6 got=%h exp=0", reg2ScalarContent); end
    tests++; if (reg2VectorContent !== '0) begin fails++; $display("FAIL dual_v6 got=%h exp=0", reg2VectorContent); end
  endtask

  task automatic test_reset_midwrite();
    idle_inputs();
    instruction       = mk_instr(5'd9, 3'd1, 3'd7, 3'd5, 16'd0);
    writeEnableScalar = 1'b1;
    writeEnableVector = 1'b1;
    writeAddress      = 3'd5;
    writeScalarData   = 19'd4321;
    writeVectorData   = mk_vec(50);
    #1;
    tests++; if (reg2ScalarContent !== 19'd4321) begin fails++; $display("FAIL mid_byp got=%0d exp=4321", reg2ScalarContent); end
    reset = 1'b1;
    #1;
    tests++; if (reg1ScalarContent !== '0) begin fails++; $display("FAIL mid_r1s got=%h exp=0", reg1ScalarContent); end
    tests++; if (reg2ScalarContent !== '0) begin fails++; $display("FAIL mid_r2s got=%h exp=0", reg2ScalarContent); end
    tests++; if (reg1VectorContent !== '0) begin fails++; $display("FAIL mid_r1v got=%h exp=0", reg1VectorContent); end
    tests++; if (reg2VectorContent !== '0) begin fails++; $display("FAIL mid_r2v got=%h exp=0", reg2VectorContent); end
    tests++; if (maskVectorOut !== 6'b111111) begin fails++; $display("FAIL mid_mask got=%b exp=111111", maskVectorOut); end
    tests++; if (opcode !== 5'd9) begin fails++; $display("FAIL mid_op got=%0d exp=9", opcode); end
    tick();
    idle_inputs();
    #1 reset = 1'b0;
    #1;
    tests++; if (reg2ScalarContent !== '0) begin fails++; $display("FAIL mid_lost_s got=%h exp=0", reg2ScalarContent); end
    tests++; if (reg2VectorContent !== '0) begin fails++; $display("FAIL mid_lost_v got=%h exp=0", reg2VectorContent); end
    tests++; if (reg1ScalarContent !== '0) begin fails++; $display("FAIL mid_r7_cleared got=%h exp=0", reg1ScalarContent); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    instruction     = '0;
    writeAddress    = '0;
    writeScalarData = '0;
    writeVectorData = '0;
    maskVectorIn    = '0;
    idle_inputs();
    test_reset();
    test_decode();
    test_scalar_write();
    test_vector_bypass();
    test_mask();
    test_dual_write();
    test_reset_midwrite();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
